// File: rtl/pdm_pkg.sv
// pdm_pkg: shared types and sizing helpers for the multi-channel PDM DAC
package pdm_pkg;
  typedef enum logic {PDM_FIRST = 1'b0, PDM_SECOND = 1'b1} pdm_mode_e;
  // Signed integrator width for an N-bit level
  function automatic int integ_width(input int n);
    return n + 4;
  endfunction
  // Symmetric clamp magnitude for the second-order integrators
  function automatic int sat_limit(input int n);
    return (1 << (n + 2)) - 1;
  endfunction
  // Channel index width, never below one bit
  function automatic int ch_idx_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction
endpackage

// File: rtl/pdm_channel.sv
// pdm_channel: one first/second-order sigma-delta modulator with its active level
//   clk, rst_n  : clock, async active-low reset
//   run         : low on the settle edge right after reset release
//   enable      : channel run enable; low forces the zero state
//   load        : commit strobe, loads load_level into the active level
//   clear       : mode change, forces the zero state on this edge
//   mode        : active modulator order
//   load_level  : level to become active on load
//   out         : registered PDM bit
module pdm_channel
  import pdm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         enable,
  input  logic         load,
  input  logic         clear,
  input  pdm_mode_e    mode,
  input  logic [N-1:0] load_level,
  output logic         out
);
  localparam int W = integ_width(N);
  localparam int S = W + 2;
  localparam logic signed [S-1:0] LIM = S'(sat_limit(N));
  logic [N-1:0] level_q, level_d, acc_q, acc_d;
  logic signed [W-1:0] i1_q, i1_d, i2_q, i2_d;
  logic out_q, out_d, zero;
  logic [N:0] s1;
  logic signed [S-1:0] xs, fb, i1_sat, i2_sat;
  function automatic logic signed [S-1:0] sat(input logic signed [S-1:0] v);
    return v > LIM ? LIM : v < -LIM ? -LIM : v;
  endfunction
  always_comb begin
    level_d = load ? load_level : level_q;
    zero = !run || !enable || clear;
    s1 = {1'b0, acc_q} + {1'b0, level_q};
    xs = S'({1'b0, level_q});
    fb = out_q ? S'(1 << N) : '0;
    // Sums are formed two bits wider than the integrators so the clamp sees the true value
    i1_sat = sat(S'(i1_q) + xs - fb);
    i2_sat = sat(S'(i2_q) + i1_sat - fb);
    acc_d = (zero || mode == PDM_SECOND) ? '0 : s1[N-1:0];
    i1_d = (zero || mode == PDM_FIRST) ? '0 : W'(i1_sat);
    i2_d = (zero || mode == PDM_FIRST) ? '0 : W'(i2_sat);
    // Strictly positive test keeps a zero level silent from the all-zero state
    out_d = zero ? 1'b0 : mode == PDM_FIRST ? s1[N] : (i2_sat > 0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      acc_q <= '0;
      i1_q <= '0;
      i2_q <= '0;
      out_q <= 1'b0;
    end else begin
      level_q <= level_d;
      acc_q <= acc_d;
      i1_q <= i1_d;
      i2_q <= i2_d;
      out_q <= out_d;
    end
  end
  assign out = out_q;
endmodule

// File: rtl/pdm_dac_multi.sv
// pdm_dac_multi: multi-channel PDM DAC with double-buffered levels and atomic commit
//   clk, rst_n : clock, async active-low reset
//   wr_en/wr_ch/wr_data : shadow level write (out-of-range channel ignored)
//   ch_enable  : per-channel run enable
//   mode       : modulator order, taken at commit
//   commit     : copy all shadow levels and mode to active
//   out        : one registered PDM bit per channel
module pdm_dac_multi
  import pdm_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int VALUE_BITS = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [ch_idx_width(CHANNELS)-1:0]   wr_ch,
  input  logic [VALUE_BITS-1:0]               wr_data,
  input  logic [CHANNELS-1:0]                 ch_enable,
  input  logic                                mode,
  input  logic                                commit,
  output logic [CHANNELS-1:0]                 out
);
  localparam int CW = ch_idx_width(CHANNELS);
  logic [VALUE_BITS-1:0] shadow_q [CHANNELS];
  logic [VALUE_BITS-1:0] shadow_d [CHANNELS];
  pdm_mode_e mode_q, mode_d;
  logic run_q, clear;
  always_comb begin
    // shadow_d doubles as the commit source, giving write-through on a same-cycle write
    for (int c = 0; c < CHANNELS; c++) shadow_d[c] = (wr_en && wr_ch == CW'(c)) ? wr_data : shadow_q[c];
    mode_d = commit ? pdm_mode_e'(mode) : mode_q;
    clear = commit && mode_d != mode_q;
  end
  // run_q holds the modulators idle for the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '{default: '0};
      mode_q <= PDM_FIRST;
      run_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      mode_q <= mode_d;
      run_q <= 1'b1;
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pdm_channel #(.N(VALUE_BITS)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .run(run_q),
      .enable(ch_enable[i]),
      .load(commit),
      .clear(clear),
      .mode(mode_q),
      .load_level(shadow_d[i]),
      .out(out[i])
    );
  end
endmodule
